// File: rtl/frame_sequencer_if.sv
// Handshake and datapath-control bundle between an upstream pixel source, the frame
// sequencer and its downstream pipeline. The sequencer is the slave side.
interface frame_sequencer_if #(
   parameter int unsigned MAX_PIXEL_BITS = 24
);
   logic [1:0]                mode_i;
   logic                      start_i;
   logic                      in_valid_i;
   logic                      in_ready_o;
   logic [MAX_PIXEL_BITS-1:0] in_pixel_i;
   logic [1:0]                select_o;
   logic                      start_sobel_o;
   logic                      px_rdy_o;
   logic [MAX_PIXEL_BITS-1:0] pixel_o;
   logic                      px_rdy_i;
   logic                      busy_o;
   logic                      frame_done_o;
   logic                      timeout_o;

   modport slave (
      input  mode_i, start_i, in_valid_i, in_pixel_i, px_rdy_i,
      output in_ready_o, select_o, start_sobel_o, px_rdy_o, pixel_o, busy_o, frame_done_o,
             timeout_o
   );

   modport master (
      output mode_i, start_i, in_valid_i, in_pixel_i, px_rdy_i,
      input  in_ready_o, select_o, start_sobel_o, px_rdy_o, pixel_o, busy_o, frame_done_o,
             timeout_o
   );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame of pixels into the datapath, then waits for the
// expected number of output strobes (or an idle timeout) before signalling completion.
module frame_sequencer #(
   parameter int unsigned IMG_WIDTH      = 16,
   parameter int unsigned IMG_HEIGHT     = 16,
   parameter int unsigned MAX_PIXEL_BITS = 24,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic              clk_i,
   input logic              nreset_i,
   frame_sequencer_if.slave bus
);
   localparam int unsigned NumPixels = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned NumInner  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
   localparam int unsigned CntW      = $clog2(NumPixels + 1);
   localparam int unsigned IdleW     = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CntW-1:0]  LastIn   = CntW'(NumPixels - 1);
   localparam logic [CntW-1:0]  ExpFull  = CntW'(NumPixels);
   localparam logic [CntW-1:0]  ExpInner = CntW'(NumInner);
   localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {StIdle, StStart, StStream, StDrain, StDone} state_e;

   state_e                    state_q, state_d;
   logic [1:0]                select_q, select_d;
   logic [CntW-1:0]           in_cnt_q, in_cnt_d;
   logic [CntW-1:0]           out_cnt_q, out_cnt_d;
   logic [IdleW-1:0]          idle_cnt_q, idle_cnt_d;
   logic                      timeout_q, timeout_d;
   logic                      px_rdy_q;
   logic [MAX_PIXEL_BITS-1:0] pixel_q;

   logic [CntW-1:0] out_expected;
   logic            accept;
   logic            out_strobe;

   // Sobel modes (00/01) lose the one-pixel border on every side.
   assign out_expected = select_q[1] ? ExpFull : ExpInner;
   assign accept       = (state_q == StStream) && bus.in_valid_i;
   assign out_strobe   = bus.px_rdy_i && ((state_q == StStream) || (state_q == StDrain));

   always_comb begin
      state_d    = state_q;
      select_d   = select_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      idle_cnt_d = idle_cnt_q;
      timeout_d  = timeout_q;

      if (out_strobe && (out_cnt_q < out_expected)) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start_i) begin
               select_d   = bus.mode_i;
               in_cnt_d   = '0;
               out_cnt_d  = '0;
               idle_cnt_d = '0;
               timeout_d  = 1'b0;
               state_d    = StStart;
            end
         end
         StStart: state_d = StStream;
         StStream: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == LastIn) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // Completion wins over a timeout expiring in the same cycle.
            if (out_cnt_d >= out_expected) begin
               state_d = StDone;
            end else if (bus.px_rdy_i) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q >= IdleMax - 1'b1) begin
               idle_cnt_d = IdleMax;
               timeout_d  = 1'b1;
               state_d    = StDone;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q    <= StIdle;
         select_q   <= 2'b00;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
         px_rdy_q   <= 1'b0;
         pixel_q    <= '0;
      end else begin
         state_q    <= state_d;
         select_q   <= select_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= timeout_d;
         px_rdy_q   <= accept;
         if (accept) begin
            pixel_q <= bus.in_pixel_i;
         end
      end
   end

   assign bus.in_ready_o    = (state_q == StStream);
   assign bus.busy_o        = (state_q != StIdle);
   assign bus.start_sobel_o = (state_q == StStart) && !select_q[1];
   assign bus.frame_done_o  = (state_q == StDone);
   assign bus.select_o      = select_q;
   assign bus.px_rdy_o      = px_rdy_q;
   assign bus.pixel_o       = pixel_q;
   assign bus.timeout_o     = timeout_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: table of whole-frame scenarios plus hand-written reset and
// back-to-back start sequences; accepted pixels are checked through a scoreboard queue.
module tb_frame_sequencer;
   localparam int unsigned PixBits = 24;

   logic clk;
   logic nreset;

   frame_sequencer_if #(.MAX_PIXEL_BITS(PixBits)) bus ();

   frame_sequencer #(
      .IMG_WIDTH      (16),
      .IMG_HEIGHT     (16),
      .MAX_PIXEL_BITS (PixBits),
      .TIMEOUT_CYCLES (1023)
   ) dut (
      .clk_i    (clk),
      .nreset_i (nreset),
      .bus      (bus)
   );

   typedef struct {
      logic [1:0] mode;
      int         valid_pct;
      int         n_pxrdy;
      int         exp_strobes;
      int         exp_sobel;
      logic       exp_timeout;
      int         exp_drain;
   } vec_t;

   int n_tests = 0;
   int n_fail = 0;
   int n_strobe = 0;
   int n_done = 0;
   int n_sobel = 0;
   int n_idle = 0;
   int drain_len = 0;
   int drain_at_done = 0;
   int echoed = 0;
   int px_limit = 0;
   logic [PixBits-1:0] sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream datapath model: echo the first px_limit strobes back as output strobes.
   assign bus.px_rdy_i = bus.px_rdy_o && (echoed < px_limit);

   always @(posedge clk) begin
      if (bus.px_rdy_i) echoed <= echoed + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.px_rdy_o) begin
         n_strobe++;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pixel_out: strobe with value 0x%0h but no accepted pixel pending",
                     bus.pixel_o);
         end else begin
            check("pixel_out", 32'(bus.pixel_o), 32'(sb.pop_front()));
         end
      end
      if (bus.start_sobel_o) n_sobel++;
      if (!bus.busy_o) n_idle++;
      if (bus.frame_done_o) begin
         n_done++;
         drain_at_done = drain_len;
      end
      if (bus.in_ready_o) drain_len = 0;
      else if (bus.busy_o && !bus.frame_done_o) drain_len++;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input int valid_pct, input bit rand_mode);
      if (rand_mode) bus.mode_i = 2'($urandom_range(3));
      bus.in_valid_i = ($urandom_range(99) < valid_pct);
      bus.in_pixel_i = PixBits'($urandom);
      if (bus.in_valid_i && bus.in_ready_o) sb.push_back(bus.in_pixel_i);
      tick();
   endtask

   function automatic logic [31:0] all_outputs();
      return {bus.select_o, bus.pixel_o, bus.start_sobel_o, bus.px_rdy_o, bus.in_ready_o,
              bus.busy_o, bus.frame_done_o, bus.timeout_o};
   endfunction

   task automatic run_frame(input vec_t v);
      int s0, d0, k0, cyc;
      s0 = n_strobe;
      d0 = n_done;
      k0 = n_sobel;
      px_limit = echoed + v.n_pxrdy;
      tick();
      bus.mode_i = v.mode;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("busy_in_start", 32'(bus.busy_o), 32'd1);
      check("timeout_cleared", 32'(bus.timeout_o), 32'd0);
      cyc = 0;
      while (n_done == d0 && cyc < 4000) begin
         drive(v.valid_pct, 1'b1);
         cyc++;
      end
      check("select_held", 32'(bus.select_o), 32'(v.mode));
      check("timeout_flag", 32'(bus.timeout_o), 32'(v.exp_timeout));
      check("drain_cycles", 32'(drain_at_done), 32'(v.exp_drain));
      bus.in_valid_i = 1'b0;
      repeat (3) tick();
      check("frame_done_count", 32'(n_done - d0), 32'd1);
      check("strobe_count", 32'(n_strobe - s0), 32'(v.exp_strobes));
      check("sobel_pulses", 32'(n_sobel - k0), 32'(v.exp_sobel));
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("idle_after_frame", 32'(bus.busy_o), 32'd0);
   endtask

   vec_t vecs[6];

   initial begin
      int s0, d0, i0, cyc, acc;
      //          mode  valid% pxrdy   strobes sobel timeout drain
      vecs[0] = '{2'b10, 100, 100000, 256, 0, 1'b0, 1};
      vecs[1] = '{2'b00, 100, 196,    256, 1, 1'b0, 1};
      vecs[2] = '{2'b11, 60,  100000, 256, 0, 1'b0, 1};
      vecs[3] = '{2'b01, 100, 150,    256, 1, 1'b1, 1023};
      vecs[4] = '{2'b01, 70,  100000, 256, 1, 1'b0, 1};
      vecs[5] = '{2'b00, 100, 0,      256, 1, 1'b1, 1023};

      nreset = 1'b1;
      bus.mode_i = 2'b00;
      bus.start_i = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.in_pixel_i = '0;
      #2 nreset = 1'b0;
      #1 check("reset_outputs", all_outputs(), 32'd0);
      repeat (3) tick();
      nreset = 1'b1;
      tick();
      check("idle_after_reset", 32'(bus.busy_o), 32'd0);

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // start_i held high: back-to-back frames with exactly one idle cycle between them.
      s0 = n_strobe;
      d0 = n_done;
      px_limit = echoed + 100000;
      bus.mode_i = 2'b10;
      bus.start_i = 1'b1;
      i0 = n_idle;
      cyc = 0;
      while ((n_done - d0) < 2 && cyc < 2000) begin
         drive(100, 1'b0);
         cyc++;
      end
      bus.start_i = 1'b0;
      check("held_idle_gap", 32'(n_idle - i0), 32'd1);
      bus.in_valid_i = 1'b0;
      repeat (4) tick();
      check("held_done_count", 32'(n_done - d0), 32'd2);
      check("held_strobe_count", 32'(n_strobe - s0), 32'd512);
      check("held_stops", 32'(bus.busy_o), 32'd0);

      // Reset after 100 accepted pixels aborts the frame silently.
      d0 = n_done;
      px_limit = echoed + 100000;
      bus.mode_i = 2'b10;
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 100 && cyc < 1000) begin
         if (bus.in_ready_o) acc++;
         drive(100, 1'b0);
         cyc++;
      end
      check("accepted_before_reset", 32'(acc), 32'd100);
      #1 nreset = 1'b0;
      #1 check("midframe_reset_outputs", all_outputs(), 32'd0);
      sb.delete();
      bus.in_valid_i = 1'b0;
      repeat (2) tick();
      nreset = 1'b1;
      repeat (2) tick();
      check("no_done_on_abort", 32'(n_done - d0), 32'd0);
      run_frame(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 16, pixels per line (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 16, lines per frame (>=3).
REQ-003 SHALL have parameter MAX_PIXEL_BITS, default 24, RGB pixel width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1023, max idle cycles allowed in DRAIN.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 nreset_i  in  1  asynchronous, active-low reset.
REQ-007 mode_i  in  2  requested pipeline mode (00 full, 01 sobel only, 10 gray only, 11 bypass).
REQ-008 start_i  in  1  frame start request, level sampled in IDLE.
REQ-009 in_valid_i  in  1  upstream pixel valid.
REQ-010 in_ready_o  out  1  sequencer accepts pixel this cycle.
REQ-011 in_pixel_i  in  MAX_PIXEL_BITS  upstream pixel.
REQ-012 select_o  out  2  pipeline mode driven to datapath.
REQ-013 start_sobel_o  out  1  one-cycle start pulse to sobel engine.
REQ-014 px_rdy_o  out  1  one-cycle pixel strobe to datapath.
REQ-015 pixel_o  out  MAX_PIXEL_BITS  registered pixel to datapath.
REQ-016 px_rdy_i  in  1  datapath output pixel strobe.
REQ-017 busy_o  out  1  high in every state except IDLE.
REQ-018 frame_done_o  out  1  one-cycle pulse at frame completion.
REQ-019 timeout_o  out  1  sticky error flag, cleared by next accepted start_i.

Function
REQ-020 States SHALL be IDLE, START, STREAM, DRAIN, DONE; transitions only as stated below.
REQ-021 IDLE: start_i=1 SHALL latch mode_i into select_o, clear counters, clear timeout_o, go to START next cycle.
REQ-022 select_o SHALL be constant from START through DONE; mode_i changes outside IDLE SHALL be ignored.
REQ-023 START: start_sobel_o SHALL be 1 for exactly this one cycle if latched mode is 00 or 01, else 0; next state STREAM.
REQ-024 STREAM: in_ready_o=1; in_valid_i&in_ready_o SHALL register pixel_o=in_pixel_i and assert px_rdy_o the following cycle (latency 1).
REQ-025 in_ready_o SHALL be 0 in IDLE, START, DRAIN, DONE; at most one pixel accepted per cycle.
REQ-026 Input counter SHALL count accepted pixels; at count IMG_WIDTH*IMG_HEIGHT (last accept) state SHALL go to DRAIN next cycle.
REQ-027 Expected output count SHALL be (IMG_WIDTH-2)*(IMG_HEIGHT-2) for modes 00/01, IMG_WIDTH*IMG_HEIGHT for 10/11.
REQ-028 Output counter SHALL count px_rdy_i in STREAM and DRAIN; counts saturate at expected value; px_rdy_i ignored in IDLE/START/DONE.
REQ-029 DRAIN: output count reaching expected value SHALL go to DONE; px_rdy_i arriving in the same cycle as last input accept SHALL be counted.
REQ-030 Idle counter SHALL reset on each px_rdy_i in DRAIN; reaching TIMEOUT_CYCLES without px_rdy_i SHALL set timeout_o and go to DONE.
REQ-031 DONE: frame_done_o=1 for exactly one cycle (also on timeout); next state IDLE.
REQ-032 start_i in any non-IDLE state SHALL be ignored; no queuing.
REQ-033 Counter widths SHALL hold IMG_WIDTH*IMG_HEIGHT and TIMEOUT_CYCLES without wrap.

Reset
REQ-034 nreset_i=0 SHALL asynchronously force IDLE, counters 0, select_o=00, pixel_o=0, and start_sobel_o, px_rdy_o, in_ready_o, busy_o, frame_done_o, timeout_o all 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done_o; first post-reset frame SHALL behave as from power-up.

Verification
REQ-036 Mode 10, 16x16, in_valid_i always 1, px_rdy_i echoes px_rdy_o -> 256 px_rdy_o pulses, start_sobel_o never high, frame_done_o once, timeout_o=0.
REQ-037 Mode 00, 16x16, px_rdy_i 196 pulses during STREAM/DRAIN -> start_sobel_o one pulse in START, frame_done_o after 196th, timeout_o=0.
REQ-038 Mode 11, random in_valid_i gaps -> pixel_o equals each accepted in_pixel_i one cycle later, exactly 256 strobes, mode_i toggling mid-frame leaves select_o=11.
REQ-039 Mode 01, only 150 px_rdy_i then silence -> timeout_o=1 after 1023 idle cycles in DRAIN, frame_done_o one pulse, next start_i clears timeout_o.
REQ-040 nreset_i pulsed low after 100 accepted pixels -> all outputs 0 immediately, no frame_done_o; subsequent full 16x16 frame completes normally.
REQ-041 start_i held high continuously -> back-to-back frames, each IDLE->START->STREAM->DRAIN->DONE, start_i ignored while busy_o=1.
